// File: rtl/shield_write_line_assembler_if.sv
// Bundle of the CL write-data channel, the request channel and the line
// output channel of the write line assembler.
//
// Handshakes: each channel transfers on a rising clk edge where its valid
// and ready are both high. The sender keeps valid and its payload stable
// until that transfer happens. The receiver may change ready freely.
// Channels: W (s_axi_wvalid/s_axi_wready), request (req_val/req_rdy) and
// line out (cache_line_val/cache_line_rdy).
interface shield_write_line_assembler_if #(
  parameter int CL_ID_WIDTH   = 6,
  parameter int CL_DATA_WIDTH = 64,
  parameter int LINE_WIDTH    = 512,
  parameter int OFFSET_WIDTH  = 6
);
  localparam int BEATS = LINE_WIDTH / CL_DATA_WIDTH;

  logic [CL_ID_WIDTH-1:0]       s_axi_wid;
  logic [CL_DATA_WIDTH-1:0]     s_axi_wdata;
  logic [CL_DATA_WIDTH/8-1:0]   s_axi_wstrb;
  logic                         s_axi_wlast;
  logic                         s_axi_wvalid;
  logic                         s_axi_wready;
  logic [7:0]                   req_burst_count;
  logic [OFFSET_WIDTH-1:0]      req_start_offset;
  logic                         req_val;
  logic                         req_rdy;
  logic [LINE_WIDTH-1:0]        cache_line;
  logic [LINE_WIDTH/8-1:0]      cache_line_byte_en;
  logic [BEATS-1:0]             cache_line_beat_en;
  logic                         cache_line_last;
  logic                         cache_line_val;
  logic                         cache_line_rdy;

  // Assembler side
  modport slave (
    input  s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    input  req_burst_count, req_start_offset, req_val,
    output req_rdy,
    output cache_line, cache_line_byte_en, cache_line_beat_en, cache_line_last, cache_line_val,
    input  cache_line_rdy
  );

  // CL / shield datapath side
  modport master (
    output s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    output req_burst_count, req_start_offset, req_val,
    input  req_rdy,
    input  cache_line, cache_line_byte_en, cache_line_beat_en, cache_line_last, cache_line_val,
    output cache_line_rdy
  );
endinterface

// File: rtl/shield_write_line_assembler.sv
// Write line assembler: collects W beats into two ping-pong line buffers
// (data, byte enables, beat enables) and emits complete lines in close
// order. Requests may start mid-line and span several lines. A WLAST that
// disagrees with the beat count produces a one-cycle err_wlast pulse.
module shield_write_line_assembler #(
  parameter int CL_ID_WIDTH   = 6,
  parameter int CL_DATA_WIDTH = 64,
  parameter int LINE_WIDTH    = 512,
  parameter int OFFSET_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  shield_write_line_assembler_if.slave  bus,
  output logic                          busy,
  output logic                          err_wlast,
  output logic                          dbg_state
);
  localparam int BEATS  = LINE_WIDTH / CL_DATA_WIDTH;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRB_W = CL_DATA_WIDTH / 8;
  localparam int BEN_W  = LINE_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               req_rdy_q, req_rdy_d;
  logic               wready_q, wready_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [7:0]         remaining_q, remaining_d;
  logic               alloc_q, alloc_d;     // buffer wr_sel is open for assembly
  logic               wr_sel_q, wr_sel_d;   // buffer being assembled
  logic               rd_sel_q, rd_sel_d;   // oldest closed buffer
  logic [1:0]         full_q, full_d;
  logic [1:0]         last_q, last_d;
  logic [LINE_WIDTH-1:0] data_q [2];
  logic [LINE_WIDTH-1:0] data_d [2];
  logic [BEN_W-1:0]      be_q   [2];
  logic [BEN_W-1:0]      be_d   [2];
  logic [BEATS-1:0]      ben_q  [2];
  logic [BEATS-1:0]      ben_d  [2];

  logic accept_req;
  logic beat_acc;
  logic final_beat;
  logic [IDX_W-1:0] start_idx;

  // Only the beat-select bits of the offset matter; wid is not used.
  logic unused_inputs;
  assign unused_inputs = ^{bus.s_axi_wid, bus.req_start_offset};

  assign start_idx = (BEATS > 1) ? bus.req_start_offset[OFFSET_WIDTH-1 -: IDX_W] : '0;

  // Next-state logic: request accept, beat assembly, line close and drain.
  // Because wready is registered from next state, a buffer freed by a drain
  // is only allocatable from the following cycle. Lines close alternately
  // into the two buffers and drain alternately, so output follows close order.
  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    remaining_d = remaining_q;
    alloc_d     = alloc_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    last_d      = last_q;
    data_d      = data_q;
    be_d        = be_q;
    ben_d       = ben_q;
    err_d       = 1'b0;

    accept_req = (state_q == S_IDLE) && req_rdy_q && bus.req_val;
    beat_acc   = (state_q == S_FILL) && wready_q && bus.s_axi_wvalid;
    final_beat = (remaining_q == 8'd1);

    if (accept_req && (bus.req_burst_count != 8'd0)) begin
      state_d     = S_FILL;
      beat_idx_d  = start_idx;
      remaining_d = bus.req_burst_count;
    end

    if (beat_acc) begin
      if (!alloc_q) begin
        data_d[wr_sel_q] = '0;
        be_d[wr_sel_q]   = '0;
        ben_d[wr_sel_q]  = '0;
      end
      data_d[wr_sel_q][beat_idx_q*CL_DATA_WIDTH +: CL_DATA_WIDTH] = bus.s_axi_wdata;
      be_d[wr_sel_q][beat_idx_q*STRB_W +: STRB_W]                 = bus.s_axi_wstrb;
      ben_d[wr_sel_q][beat_idx_q]                                 = 1'b1;
      alloc_d     = 1'b1;
      remaining_d = remaining_q - 8'd1;
      beat_idx_d  = (beat_idx_q == IDX_LAST) ? '0 : beat_idx_q + 1'b1;
      err_d       = (bus.s_axi_wlast != final_beat);
      if ((beat_idx_q == IDX_LAST) || final_beat) begin
        full_d[wr_sel_q] = 1'b1;
        last_d[wr_sel_q] = final_beat;
        alloc_d          = 1'b0;
        wr_sel_d         = ~wr_sel_q;
        if (final_beat) begin
          state_d = S_IDLE;
        end
      end
    end

    if (full_q[rd_sel_q] && bus.cache_line_rdy) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    req_rdy_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_FILL) && (alloc_d || !full_d[wr_sel_d]);
  end

  // State and buffer registers; reset discards every pending line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_rdy_q   <= 1'b0;
      wready_q    <= 1'b0;
      err_q       <= 1'b0;
      beat_idx_q  <= '0;
      remaining_q <= '0;
      alloc_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= '0;
      last_q      <= '0;
      data_q      <= '{default: '0};
      be_q        <= '{default: '0};
      ben_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      req_rdy_q   <= req_rdy_d;
      wready_q    <= wready_d;
      err_q       <= err_d;
      beat_idx_q  <= beat_idx_d;
      remaining_q <= remaining_d;
      alloc_q     <= alloc_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      last_q      <= last_d;
      data_q      <= data_d;
      be_q        <= be_d;
      ben_q       <= ben_d;
    end
  end

  // Line output presents the oldest FULL buffer, zero when none is valid.
  assign bus.cache_line_val     = full_q[rd_sel_q];
  assign bus.cache_line         = full_q[rd_sel_q] ? data_q[rd_sel_q] : '0;
  assign bus.cache_line_byte_en = full_q[rd_sel_q] ? be_q[rd_sel_q]   : '0;
  assign bus.cache_line_beat_en = full_q[rd_sel_q] ? ben_q[rd_sel_q]  : '0;
  assign bus.cache_line_last    = full_q[rd_sel_q] && last_q[rd_sel_q];
  assign bus.req_rdy            = req_rdy_q;
  assign bus.s_axi_wready       = wready_q;
  assign busy                   = (state_q != S_IDLE) || (|full_q);
  assign err_wlast              = err_q;
  assign dbg_state              = logic'(state_q);
endmodule

// File: tb/tb_shield_write_line_assembler.sv
// Bench for shield_write_line_assembler: table of requests plus hand-written
// sequences for latency, back-pressure and asynchronous reset.
module tb_shield_write_line_assembler;
  localparam int IW = 6, DW = 64, LW = 512, OW = 6;
  localparam int BEATS = LW / DW, SW = DW / 8, BW = LW / 8;
  localparam int EXP_W = 1 + BEATS + BW + LW;

  logic clk = 1'b0;
  logic rst;
  logic busy, err_wlast, dbg_state;

  shield_write_line_assembler_if #(.CL_ID_WIDTH(IW), .CL_DATA_WIDTH(DW),
    .LINE_WIDTH(LW), .OFFSET_WIDTH(OW)) bus ();

  shield_write_line_assembler #(.CL_ID_WIDTH(IW), .CL_DATA_WIDTH(DW),
    .LINE_WIDTH(LW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_wlast(err_wlast),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_fail = 0;
  int obs_lines = 0;
  int obs_err = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Reference line being assembled by the bench model
  int m_idx, m_k, m_cnt;
  logic [LW-1:0]    m_data;
  logic [BW-1:0]    m_be;
  logic [BEATS-1:0] m_ben;

  typedef struct {
    int off;
    int cnt;
    int mode;   // 0: all strobes, 1: 0x0F on first beat, 2: random strobes
    int bad;    // beat index whose wlast is inverted, -1 none
    int lines;  // expected number of lines
    int errs;   // expected err_wlast pulses
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each consumed line with the oldest expected line
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    #2;
    if (!rst) begin
      if (err_wlast) obs_err++;
      if (bus.cache_line_val && bus.cache_line_rdy) begin
        obs_lines++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_line: got beat_en %0h with no line expected", bus.cache_line_beat_en);
        end else begin
          e = exp_q.pop_front();
          check("line_data",    bus.cache_line,         e[LW-1:0]);
          check("line_byte_en", bus.cache_line_byte_en, e[LW+BW-1:LW]);
          check("line_beat_en", bus.cache_line_beat_en, e[LW+BW+BEATS-1:LW+BW]);
          check("line_last",    bus.cache_line_last,    e[EXP_W-1]);
        end
      end
    end
  end

  task automatic model_clear();
    m_data = '0;
    m_be   = '0;
    m_ben  = '0;
  endtask

  // Drivers: called at a negedge, return at a negedge
  task automatic start_req(input int off, input int cnt);
    int t = 0;
    while (!bus.req_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_rdy_wait", bus.req_rdy, 1'b1);
    bus.req_val          = 1'b1;
    bus.req_start_offset = off[OW-1:0];
    bus.req_burst_count  = cnt[7:0];
    m_idx = (off / SW) % BEATS;
    m_k   = 0;
    m_cnt = cnt;
    model_clear();
    @(negedge clk);
    bus.req_val = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic wl, input int budget, output bit ok);
    int t = 0;
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wdata  = d;
    bus.s_axi_wstrb  = s;
    bus.s_axi_wlast  = wl;
    while (!bus.s_axi_wready && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_axi_wready) begin
      ok = 1'b0;
      bus.s_axi_wvalid = 1'b0;
      return;
    end
    ok = 1'b1;
    m_data[m_idx*DW +: DW] = d;
    m_be[m_idx*SW +: SW]   = s;
    m_ben[m_idx]           = 1'b1;
    if (m_idx == BEATS-1 || m_k == m_cnt-1) begin
      exp_q.push_back({(m_k == m_cnt-1), m_ben, m_be, m_data});
      model_clear();
    end
    m_idx = (m_idx == BEATS-1) ? 0 : m_idx + 1;
    m_k++;
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0;
  endtask

  task automatic beat_or_fail(input int k, input int mode, input int bad, input int cnt);
    bit ok;
    logic [SW-1:0] s;
    logic wl;
    s  = (mode == 2) ? SW'($urandom_range(0, 255)) : ((mode == 1 && k == 0) ? 8'h0F : 8'hFF);
    wl = (k == cnt-1) ^ (k == bad);
    send_beat({$urandom, $urandom}, s, wl, 100, ok);
    if (!ok) check("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.cache_line_val) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", (exp_q.size() == 0), 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_row(input int i);
    obs_lines = 0;
    obs_err   = 0;
    start_req(tbl[i].off, tbl[i].cnt);
    for (int k = 0; k < tbl[i].cnt; k++) beat_or_fail(k, tbl[i].mode, tbl[i].bad, tbl[i].cnt);
    wait_drain();
    check($sformatf("row%0d_lines", i), obs_lines, tbl[i].lines);
    check($sformatf("row%0d_errs", i),  obs_err,   tbl[i].errs);
    check($sformatf("row%0d_idle", i),  busy,      1'b0);
  endtask

  initial begin
    int hi;
    bit ok;
    tbl[0] = '{off: 'h10, cnt: 3,  mode: 0, bad: -1, lines: 1, errs: 0};
    tbl[1] = '{off: 'h30, cnt: 4,  mode: 0, bad: -1, lines: 2, errs: 0};
    tbl[2] = '{off: 'h00, cnt: 1,  mode: 1, bad: -1, lines: 1, errs: 0};
    tbl[3] = '{off: 'h30, cnt: 4,  mode: 0, bad: 1,  lines: 2, errs: 1};
    tbl[4] = '{off: 'h00, cnt: 4,  mode: 0, bad: 3,  lines: 1, errs: 1};
    tbl[5] = '{off: 'h3F, cnt: 9,  mode: 2, bad: -1, lines: 2, errs: 0};
    tbl[6] = '{off: 'h08, cnt: 20, mode: 2, bad: -1, lines: 3, errs: 0};
    tbl[7] = '{off: 'h00, cnt: 0,  mode: 0, bad: -1, lines: 0, errs: 0};
    tbl[8] = '{off: 'h20, cnt: 8,  mode: 2, bad: -1, lines: 2, errs: 0};

    // Reset block
    rst = 1'b1;
    bus.s_axi_wid = '0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.req_burst_count = '0; bus.req_start_offset = '0; bus.req_val = 1'b0;
    bus.cache_line_rdy = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_req_rdy", bus.req_rdy,        1'b0);
    check("rst_wready",  bus.s_axi_wready,   1'b0);
    check("rst_val",     bus.cache_line_val, 1'b0);
    check("rst_busy",    busy,               1'b0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_req_rdy", bus.req_rdy,      1'b1);
    check("idle_wready",  bus.s_axi_wready, 1'b0);
    check("idle_state",   dbg_state,        1'b0);

    // Latency and exact enables of a mid-line three-beat request
    bus.cache_line_rdy = 1'b0;
    obs_lines = 0;
    start_req('h10, 3);
    check("fill_state", dbg_state, 1'b1);
    for (int k = 0; k < 2; k++) begin
      beat_or_fail(k, 0, -1, 3);
      check("val_before_close", bus.cache_line_val, 1'b0);
    end
    beat_or_fail(2, 0, -1, 3);
    #1;
    check("val_after_close", bus.cache_line_val,     1'b1);
    check("t1_beat_en",      bus.cache_line_beat_en, 8'h1C);
    check("t1_byte_en",      bus.cache_line_byte_en, 64'h0000_00FF_FFFF_0000);
    check("t1_last",         bus.cache_line_last,    1'b1);
    @(negedge clk);
    bus.cache_line_rdy = 1'b1;
    wait_drain();
    check("t1_lines", obs_lines, 1);

    // Table of requests
    for (int i = 0; i < 9; i++) run_row(i);

    // Back-pressure: both buffers full after 16 beats, then drain and resume
    bus.cache_line_rdy = 1'b0;
    obs_lines = 0;
    start_req('h00, 20);
    for (int k = 0; k < 16; k++) beat_or_fail(k, 2, -1, 20);
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.s_axi_wready) hi++;
      @(negedge clk);
    end
    check("bp_wready_cycles", hi, 0);
    check("bp_val",  bus.cache_line_val, 1'b1);
    check("bp_busy", busy,               1'b1);
    bus.cache_line_rdy = 1'b1;
    for (int k = 16; k < 20; k++) beat_or_fail(k, 2, -1, 20);
    wait_drain();
    check("bp_lines", obs_lines, 3);

    // Asynchronous reset mid-FILL with a line waiting
    bus.cache_line_rdy = 1'b0;
    start_req('h00, 10);
    for (int k = 0; k < 9; k++) beat_or_fail(k, 0, -1, 10);
    check("pre_rst_val", bus.cache_line_val, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_val",     bus.cache_line_val,     1'b0);
    check("arst_wready",  bus.s_axi_wready,       1'b0);
    check("arst_req_rdy", bus.req_rdy,            1'b0);
    check("arst_busy",    busy,                   1'b0);
    check("arst_err",     err_wlast,              1'b0);
    check("arst_line",    bus.cache_line,         '0);
    check("arst_byte_en", bus.cache_line_byte_en, '0);
    check("arst_beat_en", bus.cache_line_beat_en, '0);
    check("arst_last",    bus.cache_line_last,    1'b0);
    check("arst_state",   dbg_state,              1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.cache_line_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_req_rdy", bus.req_rdy, 1'b1);
    check("post_rst_busy",    busy,        1'b0);
    run_row(0);
    run_row(1);

    // A beat offered with no request in flight is not taken
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wdata  = '1;
    bus.s_axi_wstrb  = '1;
    repeat (3) @(negedge clk);
    check("stray_beat_wready", bus.s_axi_wready, 1'b0);
    check("stray_beat_val",    bus.cache_line_val, 1'b0);
    bus.s_axi_wvalid = 1'b0;
    send_beat('0, '0, 1'b0, 0, ok);
    check("stray_beat_refused", ok, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
